nibble_parity_rx: RTL and testbench



---
 rtl/nibble_parity_pkg.sv | 21 ++
 rtl/nibble_parity_rx_parity4_check.sv | 11 +
 rtl/nibble_parity_rx.sv | 104 ++++++++++
 tb/tb_nibble_parity_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_parity_pkg.sv
// Shared definitions for the nibble-plus-parity serial receiver.
package nibble_parity_pkg;

    // Number of data bits carried in one frame
    localparam int DATA_BITS = 4;

    // Width of the data-bit index register
    localparam int IDX_W = $clog2(DATA_BITS);

    // Index of the last data bit (D3), after which parity follows
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Receiver frame-tracking states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_parity_rx_parity4_check.sv
// Even-parity checker for a 4-bit nibble plus its parity bit.
module parity4_check (
    input  logic [3:0] d,
    input  logic       p,
    output logic       err
);

    // A nonzero XOR over data and parity means the frame is not even-parity
    assign err = ^{d, p};

endmodule

// File: rtl/nibble_parity_rx.sv
// Serial receiver for framed nibbles: start, D0..D3 (LSB first), even parity, stop.
// Reports data, parity/framing errors and keeps a saturating bad-frame count.
module nibble_parity_rx
    import nibble_parity_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_en,
    input  logic                 sin,
    output logic [3:0]           data_out,
    output logic                 p_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    state_t                 state;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   p_bit;
    logic                   chk_err;
    logic                   frame_done;
    logic                   bad_frame;

    parity4_check u_parity4_check (
        .d   (shreg),
        .p   (p_bit),
        .err (chk_err)
    );

    // The stop sample is the edge that closes a frame
    assign frame_done = bit_en && (state == STOP);
    assign bad_frame  = chk_err || !sin;

    // Frame FSM: tracks position within the frame and assembles the nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            p_bit   <= 1'b0;
            busy    <= 1'b0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sin) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                DATA: begin
                    shreg[bit_idx] <= sin;
                    bit_idx        <= bit_idx + IDX_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    p_bit <= sin;
                    state <= STOP;
                end
                STOP: begin
                    // A low stop sample is consumed here, never reused as a start
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Result registers: latch the frame on the stop edge and hold until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            p_out      <= 1'b0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            valid <= 1'b0;
            if (frame_done) begin
                data_out   <= shreg;
                p_out      <= p_bit;
                parity_err <= chk_err;
                frame_err  <= !sin;
                valid      <= 1'b1;
                if (bad_frame && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Randomized and directed bench for nibble_parity_rx, checked every cycle
// against a sample-collecting reference model. Two instances share stimulus:
// default counter width, and a 2-bit counter to exercise saturation.
module tb_nibble_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       sin;

    logic [3:0] data_out,   data_out_s;
    logic       p_out,      p_out_s;
    logic       valid,      valid_s;
    logic       parity_err, parity_err_s;
    logic       frame_err,  frame_err_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;
    logic       busy,       busy_s;

    int total;
    int bad;

    // reference model state
    int         m_nsamp;
    logic [6:0] m_frame;
    logic [3:0] m_data;
    logic       m_p;
    logic       m_valid;
    logic       m_perr;
    logic       m_ferr;
    int         m_cnt8;
    int         m_cnt2;

    nibble_parity_rx #(.ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sin        (sin),
        .data_out   (data_out),
        .p_out      (p_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    nibble_parity_rx #(.ERR_CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sin        (sin),
        .data_out   (data_out_s),
        .p_out      (p_out_s),
        .valid      (valid_s),
        .parity_err (parity_err_s),
        .frame_err  (frame_err_s),
        .err_count  (err_count_s),
        .busy       (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nsamp = 0;
        m_frame = '0;
        m_data  = '0;
        m_p     = 1'b0;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endtask

    // One clock edge of the reference: collect samples, resolve a 7-sample frame
    task automatic model_edge(input logic en, input logic s);
        m_valid = 1'b0;
        if (en) begin
            if (m_nsamp == 0) begin
                if (s == 1'b0) begin
                    m_frame[0] = 1'b0;
                    m_nsamp    = 1;
                end
            end else begin
                m_frame[m_nsamp] = s;
                m_nsamp++;
                if (m_nsamp == 7) begin
                    m_data  = m_frame[4:1];
                    m_p     = m_frame[5];
                    m_perr  = ((m_frame[1] + m_frame[2] + m_frame[3] + m_frame[4] + m_frame[5]) % 2) != 0;
                    m_ferr  = (m_frame[6] == 1'b0);
                    m_valid = 1'b1;
                    if (m_perr || m_ferr) begin
                        if (m_cnt8 < 255) m_cnt8++;
                        if (m_cnt2 < 3)   m_cnt2++;
                    end
                    m_nsamp = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic m_busy;
        m_busy = (m_nsamp != 0);
        check("data_out",   32'(data_out),   32'(m_data));
        check("p_out",      32'(p_out),      32'(m_p));
        check("valid",      32'(valid),      32'(m_valid));
        check("parity_err", 32'(parity_err), 32'(m_perr));
        check("frame_err",  32'(frame_err),  32'(m_ferr));
        check("err_count",  32'(err_count),  32'(m_cnt8));
        check("busy",       32'(busy),       32'(m_busy));
        check("sat_valid",  32'(valid_s),    32'(m_valid));
        check("sat_data",   32'(data_out_s), 32'(m_data));
        check("sat_count",  32'(err_count_s), 32'(m_cnt2));
    endtask

    // Drive one cycle: inputs change just after an edge, outputs checked 1 unit after the next edge
    task automatic step(input logic en, input logic s);
        bit_en = en;
        sin    = s;
        @(posedge clk);
        model_edge(en, s);
        #1;
        check_all();
    endtask

    // Send 7 samples (index 0 first), with 'gap' non-strobed cycles before each sample
    task automatic send_frame(input logic [6:0] bits, input int gap);
        for (int i = 0; i < 7; i++) begin
            for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 1) != 0);
            step(1'b1, bits[i]);
        end
    endtask

    function automatic logic [6:0] mk_frame(input logic [3:0] d, input logic p, input logic stop);
        return {stop, p, d, 1'b0};
    endfunction

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int lat;

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        bit_en = 1'b0;
        sin    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // reset asserted mid-idle
        repeat (3) step(1'b1, 1'b1);
        do_reset();
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step(1'b1, 1'b1);

        // good frame 0101, P=0, with latency from start edge to valid
        bit_en = 1'b1;
        sin    = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0);
        #1;
        check_all();
        lat = 0;
        for (int i = 1; i < 7; i++) begin
            step(1'b1, mk_frame(4'b0101, 1'b0, 1'b1) >> i);
            lat++;
        end
        check("good_lat", 32'(lat), 32'd6);
        check("good_valid", 32'(valid), 32'd1);
        check("good_busy", 32'(busy), 32'd0);
        check("good_data", 32'(data_out), 32'b0101);
        check("good_perr", 32'(parity_err), 32'd0);
        check("good_cnt", 32'(err_count), 32'd0);
        step(1'b0, 1'b1);
        check("good_valid_drop", 32'(valid), 32'd0);

        // parity error: data 1011, P=0
        send_frame(mk_frame(4'b1011, 1'b0, 1'b1), 0);
        check("perr_data", 32'(data_out), 32'b1011);
        check("perr_flag", 32'(parity_err), 32'd1);
        check("perr_ferr", 32'(frame_err), 32'd0);
        check("perr_cnt", 32'(err_count), 32'd1);

        // framing error: data 1100, P=0, stop=0; the low stop is not a new start
        send_frame(mk_frame(4'b1100, 1'b0, 1'b0), 0);
        check("ferr_valid", 32'(valid), 32'd1);
        check("ferr_data", 32'(data_out), 32'b1100);
        check("ferr_perr", 32'(parity_err), 32'd0);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_cnt", 32'(err_count), 32'd2);
        step(1'b0, 1'b0);
        check("ferr_nobusy", 32'(busy), 32'd0);
        step(1'b1, 1'b1);

        // strobe every 3rd cycle: 1110, P=1
        send_frame(mk_frame(4'b1110, 1'b1, 1'b1), 2);
        check("slow_data", 32'(data_out), 32'b1110);
        check("slow_p", 32'(p_out), 32'd1);
        check("slow_perr", 32'(parity_err), 32'd0);
        step(1'b1, 1'b1);

        // reset after D1, then frame 0101
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        do_reset();
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        send_frame(mk_frame(4'b0101, 1'b0, 1'b1), 0);
        check("post_rst_data", 32'(data_out), 32'b0101);
        check("post_rst_valid", 32'(valid), 32'd1);

        // saturation on the 2-bit counter: 1,2,3,3,3 back-to-back
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(mk_frame(4'b0001, 1'b0, 1'b1), 0);
            check("sat_seq", 32'(err_count_s), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        // randomized frames, random strobe density, random error injection
        for (int f = 0; f < 60; f++) begin
            logic [3:0] d;
            logic       p;
            logic       st;
            d  = 4'($urandom_range(0, 15));
            p  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            st = ($urandom_range(0, 4) != 0);
            send_frame(mk_frame(d, p, st), $urandom_range(0, 2));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step($urandom_range(0, 1) != 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run cannot hang
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
